// File: rtl/regfile_port_arbiter_if.sv
// Request/grant bundle between the core datapath, the register file and the port arbiter.
// The slave modport is the arbiter's view; the master modport is the core/regfile side.
interface regfile_port_arbiter_if #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 4
);
    logic                alu_wr_valid;
    logic [REG_BITS-1:0] alu_wr_index;
    logic [WIDTH-1:0]    alu_wr_data;

    logic                ld_wr_valid;
    logic [REG_BITS-1:0] ld_wr_index;
    logic [WIDTH-1:0]    ld_wr_data;
    logic                ld_wr_ready;

    logic                rd_valid;
    logic [REG_BITS-1:0] rd_a_index;
    logic [REG_BITS-1:0] rd_b_index;
    logic                rd_ready;
    logic [WIDTH-1:0]    rd_a_data;
    logic [WIDTH-1:0]    rd_b_data;

    logic                rf_reg_write;
    logic [REG_BITS-1:0] rf_a_index;
    logic [REG_BITS-1:0] rf_b_index;
    logic [WIDTH-1:0]    rf_write_data;
    logic [WIDTH-1:0]    rf_a_data;
    logic [WIDTH-1:0]    rf_b_data;

    logic [1:0]          pend_count;

    modport slave (
        input  alu_wr_valid, alu_wr_index, alu_wr_data,
        input  ld_wr_valid, ld_wr_index, ld_wr_data,
        output ld_wr_ready,
        input  rd_valid, rd_a_index, rd_b_index,
        output rd_ready, rd_a_data, rd_b_data,
        output rf_reg_write, rf_a_index, rf_b_index, rf_write_data,
        input  rf_a_data, rf_b_data,
        output pend_count
    );

    modport master (
        output alu_wr_valid, alu_wr_index, alu_wr_data,
        output ld_wr_valid, ld_wr_index, ld_wr_data,
        input  ld_wr_ready,
        output rd_valid, rd_a_index, rd_b_index,
        input  rd_ready, rd_a_data, rd_b_data,
        input  rf_reg_write, rf_a_index, rf_b_index, rf_write_data,
        output rf_a_data, rf_b_data,
        input  pend_count
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Shares the register file write port and A read index between ALU writeback, a 2-deep
// load writeback queue and the operand read stage, with load hazard and WAW tracking.
module regfile_port_arbiter #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    regfile_port_arbiter_if.slave  bus
);
    localparam int DEPTH = 2;

    typedef enum logic [2:0] {
        G_IDLE,
        G_ALU,
        G_FORCE,
        G_READ,
        G_DRAIN
    } grant_t;

    // Queue storage: slot 0 is always the head.
    logic [REG_BITS-1:0] q_idx     [DEPTH];
    logic [WIDTH-1:0]    q_data    [DEPTH];
    logic [DEPTH-1:0]    q_kill;
    logic [1:0]          count;

    logic [REG_BITS-1:0] q_idx_nx  [DEPTH];
    logic [WIDTH-1:0]    q_data_nx [DEPTH];
    logic [DEPTH-1:0]    q_kill_nx;
    logic [1:0]          count_nx;

    logic [DEPTH-1:0]    occ;
    logic [DEPTH-1:0]    live;
    logic                alu_go;
    logic                ld_ready;
    logic                enq;
    logic                pop;
    logic                hazard;
    logic                slot;
    grant_t              grant;

    always_comb begin
        occ[0] = (count != 2'd0);
        occ[1] = (count == 2'd2);
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = occ[i] && !q_kill[i];
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] &&
                (((bus.rd_a_index != '0) && (bus.rd_a_index == q_idx[i])) ||
                 ((bus.rd_b_index != '0) && (bus.rd_b_index == q_idx[i])))) begin
                hazard = 1'b1;
            end
        end
    end

    assign alu_go   = reset_n && bus.alu_wr_valid && (bus.alu_wr_index != '0);
    assign ld_ready = reset_n && (count != 2'd2);
    assign enq      = bus.ld_wr_valid && ld_ready && (bus.ld_wr_index != '0);

    always_comb begin
        grant = G_IDLE;
        if (!reset_n) begin
            grant = G_IDLE;
        end else if (alu_go) begin
            grant = G_ALU;
        end else if (count == 2'd2) begin
            grant = G_FORCE;
        end else if (bus.rd_valid && !hazard) begin
            grant = G_READ;
        end else if (count != 2'd0) begin
            grant = G_DRAIN;
        end
    end

    assign pop = (grant == G_FORCE) || (grant == G_DRAIN);

    always_comb begin
        bus.rf_reg_write  = 1'b0;
        bus.rf_a_index    = bus.rd_a_index;
        bus.rf_write_data = '0;
        bus.rd_ready      = 1'b0;
        case (grant)
            G_ALU: begin
                bus.rf_reg_write  = 1'b1;
                bus.rf_a_index    = bus.alu_wr_index;
                bus.rf_write_data = bus.alu_wr_data;
            end
            G_FORCE, G_DRAIN: begin
                // A killed head still consumes its slot but must not overwrite the newer ALU value.
                bus.rf_reg_write  = !q_kill[0];
                bus.rf_a_index    = q_idx[0];
                bus.rf_write_data = q_data[0];
            end
            G_READ: begin
                bus.rd_ready = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.rf_b_index  = bus.rd_b_index;
    assign bus.rd_a_data   = bus.rf_a_data;
    assign bus.rd_b_data   = bus.rf_b_data;
    assign bus.ld_wr_ready = ld_ready;
    assign bus.pend_count  = count;

    // Enqueue slot after any pop this cycle; only meaningful when enq is set (count < 2).
    assign slot = pop ? count[1] : count[0];

    always_comb begin
        q_idx_nx  = q_idx;
        q_data_nx = q_data;
        q_kill_nx = q_kill;
        count_nx  = count - {1'b0, pop} + {1'b0, enq};

        if (alu_go) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (occ[i] && (q_idx[i] == bus.alu_wr_index)) begin
                    q_kill_nx[i] = 1'b1;
                end
            end
        end

        if (pop) begin
            q_idx_nx[0]  = q_idx[1];
            q_data_nx[0] = q_data[1];
            q_kill_nx[0] = q_kill[1];
            q_kill_nx[1] = 1'b0;
        end

        // A load accepted alongside an ALU write is the younger of the two, so it starts live.
        if (enq) begin
            q_idx_nx[slot]  = bus.ld_wr_index;
            q_data_nx[slot] = bus.ld_wr_data;
            q_kill_nx[slot] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count  <= 2'd0;
            q_kill <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_idx[i]  <= '0;
                q_data[i] <= '0;
            end
        end else begin
            count  <= count_nx;
            q_kill <= q_kill_nx;
            for (int i = 0; i < DEPTH; i++) begin
                q_idx[i]  <= q_idx_nx[i];
                q_data[i] <= q_data_nx[i];
            end
        end
    end
endmodule
